// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared constants, state type and index helper for the result buffer
package mm_pkg;

    localparam int DATA_W = 19;
    localparam int N      = 8;
    localparam int DEPTH  = N * N;
    localparam int AW     = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // (k%8)*8 + k/8 on a 6-bit index is a swap of the two 3-bit halves.
    // The mapping is its own inverse.
    function automatic logic [AW-1:0] idx_transpose(input logic [AW-1:0] k);
        return {k[2:0], k[5:3]};
    endfunction

endpackage

// File: rtl/mm_result_ram.sv
// rtl/mm_result_ram.sv - 64 x DATA_W storage, one write port, one registered read port
// Ports:
//   clk              clock
//   we/waddr/wdata   write port, written on the rising edge
//   re/raddr         read request; rdata updates one edge later
//   rdata            registered read data; holds its value while re=0
module mm_result_ram #(
    parameter int DATA_W = 19
) (
    input  logic              clk,
    input  logic              we,
    input  logic [5:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [5:0]        raddr,
    output logic [DATA_W-1:0] rdata
);
    import mm_pkg::*;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mm_result_buffer.sv
// rtl/mm_result_buffer.sv - captures a 64-word result block, checksums it, drains it as a stream
// Ports:
//   clk, reset (sync, active-low)
//   in/write_enable                     result word capture
//   clear                               soft return to IDLE
//   out_data/out_index/out_valid/out_ready  drain stream
//   wr_count, full, done, overflow, checksum  status
module mm_result_buffer #(
    parameter int DATA_W    = 19,
    parameter int N         = 8,
    parameter bit ROW_MAJOR = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in,
    input  logic                     write_enable,
    input  logic                     clear,
    output logic [DATA_W-1:0]        out_data,
    output logic [5:0]               out_index,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [6:0]               wr_count,
    output logic                     full,
    output logic                     done,
    output logic                     overflow,
    output logic signed [DATA_W+5:0] checksum
);
    import mm_pkg::*;

    localparam int CW   = DATA_W + 6;
    localparam int LAST = N * N - 1;

    state_t                state_q, state_d;
    logic [6:0]            wr_count_q, wr_count_d;
    logic signed [CW-1:0]  checksum_q, checksum_d;
    logic                  full_q, full_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;
    logic [6:0]            rd_k_q, rd_k_d;
    logic [6:0]            tx_cnt_q, tx_cnt_d;
    logic                  pend_q, pend_d;
    logic [5:0]            pend_idx_q, pend_idx_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic [5:0]            out_index_q, out_index_d;

    logic                  ram_we, ram_re;
    logic [5:0]            ram_raddr, rd_idx;
    logic [DATA_W-1:0]     ram_rdata;
    logic                  xfer, load_out, issue;

    mm_result_ram #(.DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_count_q[5:0]),
        .wdata (in),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        wr_count_d  = wr_count_q;
        checksum_d  = checksum_q;
        full_d      = full_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
        rd_k_d      = rd_k_q;
        tx_cnt_d    = tx_cnt_q;
        pend_d      = pend_q;
        pend_idx_d  = pend_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;

        ram_raddr = ROW_MAJOR ? idx_transpose(rd_k_q[5:0]) : rd_k_q[5:0];
        rd_idx    = ROW_MAJOR ? rd_k_q[5:0] : idx_transpose(rd_k_q[5:0]);

        // The RAM output register acts as the first pipeline stage: it only
        // reloads on a read, so an unconsumed word simply waits there while
        // the output register is stalled.
        xfer     = out_valid_q && out_ready;
        load_out = pend_q && (!out_valid_q || xfer);
        issue    = (state_q == ST_DRAIN) && !rd_k_q[6] && (!pend_q || load_out);

        if (clear) begin
            state_d     = ST_IDLE;
            wr_count_d  = '0;
            checksum_d  = '0;
            full_d      = 1'b0;
            done_d      = 1'b0;
            overflow_d  = 1'b0;
            rd_k_d      = '0;
            tx_cnt_d    = '0;
            pend_d      = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_index_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FILL: begin
                    if (write_enable) begin
                        ram_we     = 1'b1;
                        wr_count_d = wr_count_q + 7'd1;
                        checksum_d = checksum_q + {{6{in[DATA_W-1]}}, in};
                        state_d    = ST_FILL;
                        if (wr_count_q == 7'(LAST)) begin
                            state_d = ST_DRAIN;
                            full_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    if (write_enable) begin
                        overflow_d = 1'b1;
                    end
                end
            endcase

            if (issue) begin
                ram_re     = 1'b1;
                rd_k_d     = rd_k_q + 7'd1;
                pend_idx_d = rd_idx;
                pend_d     = 1'b1;
            end else if (load_out) begin
                pend_d = 1'b0;
            end

            if (load_out) begin
                out_valid_d = 1'b1;
                out_data_d  = ram_rdata;
                out_index_d = pend_idx_q;
            end else if (xfer) begin
                out_valid_d = 1'b0;
            end

            if (xfer) begin
                tx_cnt_d = tx_cnt_q + 7'd1;
                if (tx_cnt_q == 7'(LAST)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wr_count_q  <= '0;
            checksum_q  <= '0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            rd_k_q      <= '0;
            tx_cnt_q    <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_count_q  <= wr_count_d;
            checksum_q  <= checksum_d;
            full_q      <= full_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            rd_k_q      <= rd_k_d;
            tx_cnt_q    <= tx_cnt_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_valid = out_valid_q;
    assign wr_count  = wr_count_q;
    assign full      = full_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_mm_result_buffer.sv
// tb/tb_mm_result_buffer.sv - scoreboard bench for mm_result_buffer in row-major and column-major builds
module tb_mm_result_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, write_enable, clear, out_ready;
    logic [18:0] in_d;

    logic [18:0]        r_data, c_data;
    logic [5:0]         r_idx, c_idx;
    logic               r_valid, c_valid, r_full, c_full, r_done, c_done, r_ovf, c_ovf;
    logic [6:0]         r_cnt, c_cnt;
    logic signed [24:0] r_sum, c_sum;

    mm_result_buffer #(.DATA_W(19), .N(8), .ROW_MAJOR(1'b1)) dut_rm (
        .clk(clk), .reset(reset), .in(in_d), .write_enable(write_enable), .clear(clear),
        .out_data(r_data), .out_index(r_idx), .out_valid(r_valid), .out_ready(out_ready),
        .wr_count(r_cnt), .full(r_full), .done(r_done), .overflow(r_ovf), .checksum(r_sum)
    );

    mm_result_buffer #(.DATA_W(19), .N(8), .ROW_MAJOR(1'b0)) dut_cm (
        .clk(clk), .reset(reset), .in(in_d), .write_enable(write_enable), .clear(clear),
        .out_data(c_data), .out_index(c_idx), .out_valid(c_valid), .out_ready(out_ready),
        .wr_count(c_cnt), .full(c_full), .done(c_done), .overflow(c_ovf), .checksum(c_sum)
    );

    typedef struct {
        logic [18:0] data;
        logic [5:0]  idx;
    } exp_t;

    exp_t               q_r[$];
    exp_t               q_c[$];
    logic signed [18:0] blk [64];
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 tx_r  = 0;
    int                 tx_c  = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_write(input logic [18:0] v);
        in_d         = v;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    // Expected drain for both builds from the arrival-order block contents.
    task automatic push_exp();
        exp_t e;
        for (int k = 0; k < 64; k++) begin
            int tk;
            tk     = (k % 8) * 8 + k / 8;
            e.data = blk[tk];
            e.idx  = 6'(k);
            q_r.push_back(e);
            e.data = blk[k];
            e.idx  = 6'(tk);
            q_c.push_back(e);
        end
    endtask

    function automatic logic signed [63:0] blk_sum();
        logic signed [63:0] s;
        s = 0;
        for (int i = 0; i < 64; i++) s += blk[i];
        return s;
    endfunction

    task automatic drain(input bit toggle, input bit extra);
        for (int c = 0; c < 300 && !(r_done && c_done); c++) begin
            out_ready = toggle ? c[0] : 1'b1;
            if (extra && c >= 3 && c < 6) begin
                write_enable = 1'b1;
                in_d         = 19'd123;
            end else begin
                write_enable = 1'b0;
            end
            tick();
        end
        write_enable = 1'b0;
        out_ready    = 1'b1;
        chk("rm_done", r_done, 1);
        chk("cm_done", c_done, 1);
        chk("rm_valid_after_done", r_valid, 0);
        chk("rm_transfers", tx_r, 64);
        chk("cm_transfers", tx_c, 64);
        chk("rm_queue_left", q_r.size(), 0);
        chk("cm_queue_left", q_c.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rm_valid"}, r_valid, 0);
        chk({tag, "_rm_data"}, r_data, 0);
        chk({tag, "_rm_index"}, r_idx, 0);
        chk({tag, "_rm_count"}, r_cnt, 0);
        chk({tag, "_rm_full"}, r_full, 0);
        chk({tag, "_rm_done"}, r_done, 0);
        chk({tag, "_rm_ovf"}, r_ovf, 0);
        chk({tag, "_rm_sum"}, r_sum, 0);
        chk({tag, "_cm_valid"}, c_valid, 0);
        chk({tag, "_cm_count"}, c_cnt, 0);
        chk({tag, "_cm_sum"}, c_sum, 0);
    endtask

    // Monitor: pops the scoreboard on each transfer and checks stall stability.
    logic        r_stall = 1'b0, c_stall = 1'b0;
    logic [18:0] r_pd, c_pd;
    logic [5:0]  r_pi, c_pi;

    always @(negedge clk) begin
        exp_t e;
        if (reset && !clear) begin
            if (r_stall) chk("rm_stall_hold", {r_valid, r_data, r_idx}, {1'b1, r_pd, r_pi});
            if (c_stall) chk("cm_stall_hold", {c_valid, c_data, c_idx}, {1'b1, c_pd, c_pi});
        end
        if (r_valid && out_ready) begin
            tx_r++;
            if (q_r.size() == 0) begin
                chk("rm_unexpected_word", r_data, -1);
            end else begin
                e = q_r.pop_front();
                chk("rm_data", r_data, e.data);
                chk("rm_index", r_idx, e.idx);
            end
        end
        if (c_valid && out_ready) begin
            tx_c++;
            if (q_c.size() == 0) begin
                chk("cm_unexpected_word", c_data, -1);
            end else begin
                e = q_c.pop_front();
                chk("cm_data", c_data, e.data);
                chk("cm_index", c_idx, e.idx);
            end
        end
        r_stall = r_valid && !out_ready;
        c_stall = c_valid && !out_ready;
        r_pd = r_data; r_pi = r_idx;
        c_pd = c_data; c_pi = c_idx;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        clear        = 1'b0;
        write_enable = 1'b0;
        out_ready    = 1'b1;
        in_d         = '0;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b1;
        tick();

        // Ramp 0..63, back-to-back writes.
        for (int i = 0; i < 64; i++) blk[i] = 19'(i);
        push_exp();
        tx_r = 0; tx_c = 0;
        for (int i = 0; i < 64; i++) begin
            do_write(19'(i));
            if (i == 0) chk("first_count", r_cnt, 1);
            if (i == 62) chk("full_before_last", r_full, 0);
        end
        chk("rm_full", r_full, 1);
        chk("cm_full", c_full, 1);
        chk("rm_count64", r_cnt, 64);
        chk("valid_t0", r_valid, 0);
        tick();
        chk("valid_t1", r_valid, 0);
        tick();
        chk("valid_t2", r_valid, 1);
        drain(1'b0, 1'b0);
        chk("rm_sum_ramp", r_sum, 2016);
        chk("cm_sum_ramp", c_sum, 2016);

        // Full-scale negative words with gaps, stalled drain and dropped writes.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_zero("clear1");
        for (int i = 0; i < 64; i++) blk[i] = -19'sd262144;
        push_exp();
        tx_r = 0; tx_c = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            do_write(19'h40000);
            if (i % 16 == 5) tick();
        end
        chk("rm_sum_neg", r_sum, -16777216);
        chk("cm_sum_neg", c_sum, blk_sum());
        drain(1'b1, 1'b1);
        chk("rm_overflow", r_ovf, 1);
        chk("cm_overflow", c_ovf, 1);
        chk("rm_sum_after_ovf", r_sum, -16777216);
        chk("rm_count_after_ovf", r_cnt, 64);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_zero("clear2");

        // Clear wins over a simultaneous write.
        clear        = 1'b1;
        write_enable = 1'b1;
        in_d         = 19'd5;
        tick();
        clear        = 1'b0;
        write_enable = 1'b0;
        chk("clear_we_count", r_cnt, 0);
        chk("clear_we_ovf", r_ovf, 0);
        chk("clear_we_sum", r_sum, 0);

        // Reset mid-fill, then refill with new data.
        for (int i = 0; i < 30; i++) do_write(19'(1000 + i));
        chk("partial_count", r_cnt, 30);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("reset_mid_count", r_cnt, 0);
        chk("reset_mid_sum", r_sum, 0);
        for (int i = 0; i < 64; i++) blk[i] = 19'(500 + i);
        push_exp();
        tx_r = 0; tx_c = 0;
        for (int i = 0; i < 64; i++) do_write(19'(500 + i));
        chk("rm_sum_refill", r_sum, 34016);
        chk("cm_sum_refill", c_sum, blk_sum());
        drain(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
